// File: rtl/oddr_tap_ctrl_if.sv
// Tap-move request handshake and status between TX control logic and oddr_tap_ctrl.
// TAP_WIDTH must match the controller instance it is bound to.
interface oddr_tap_ctrl_if #(
    parameter int TAP_WIDTH = 9
);
    logic [TAP_WIDTH-1:0] tap_target;
    logic                 tap_valid;
    logic                 tap_ready;
    logic [TAP_WIDTH-1:0] tap_current;
    logic                 busy;
    logic                 tap_abort;

    modport master (
        output tap_target, tap_valid,
        input  tap_ready, tap_current, busy, tap_abort
    );

    modport slave (
        input  tap_target, tap_valid,
        output tap_ready, tap_current, busy, tap_abort
    );
endinterface

// File: rtl/oddr_tap_ctrl.sv
// Output DDR register (two SDR words per clk onto one DDR line) plus an output-delay tap
// controller that walks the delay line one tap at a time with VT compensation held off.
module oddr_tap_ctrl #(
    parameter int WIDTH       = 1,
    parameter int TAP_WIDTH   = 9,
    parameter int MAX_TAP     = 511,
    parameter int DEFAULT_TAP = 25,
    parameter int VTC_SETTLE  = 8,
    parameter int STEP_GAP    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q,
    input  logic             rdy_dlyctrl,
    oddr_tap_ctrl_if.slave   tap,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic             dly_en_vtc
);
    localparam int CNT_MAX = (VTC_SETTLE > STEP_GAP) ? VTC_SETTLE : STEP_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TAP_WIDTH-1:0] MAX_TAP_C     = TAP_WIDTH'(MAX_TAP);
    localparam logic [TAP_WIDTH-1:0] DEFAULT_TAP_C = TAP_WIDTH'(DEFAULT_TAP);

    typedef enum logic [2:0] {
        IDLE_S    = 3'd0,
        VTC_OFF_S = 3'd1,
        STEP_S    = 3'd2,
        GAP_S     = 3'd3,
        VTC_ON_S  = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [TAP_WIDTH-1:0] tgt_r, tgt_s;
    logic [TAP_WIDTH-1:0] tap_cur_r, tap_cur_s;
    logic [TAP_WIDTH-1:0] req_tgt_s;
    logic                 ce_r, ce_s;
    logic                 inc_r, inc_s;
    logic                 abort_r, abort_s;
    logic                 en_vtc_r, busy_r;
    logic                 tap_ready_s, accept_s;
    logic [WIDTH-1:0]     r1_r, r2_r, r2n_r;

    assign tap_ready_s     = (state_r == IDLE_S) & rdy_dlyctrl & ~rst;
    assign accept_s        = tap.tap_valid & tap_ready_s;
    assign req_tgt_s       = (tap.tap_target > MAX_TAP_C) ? MAX_TAP_C : tap.tap_target;

    assign tap.tap_ready   = tap_ready_s;
    assign tap.tap_current = tap_cur_r;
    assign tap.busy        = busy_r;
    assign tap.tap_abort   = abort_r;
    assign dly_ce          = ce_r;
    assign dly_inc         = inc_r;
    assign dly_en_vtc      = en_vtc_r;

    // The clock itself selects the phase, so q carries no extra register stage.
    assign q = clk ? r1_r : r2n_r;

    // Capture both SDR words on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_r <= {WIDTH{1'b0}};
            r2_r <= {WIDTH{1'b0}};
        end else begin
            r1_r <= d1;
            r2_r <= d2;
        end
    end

    // Retime the low-phase word onto the falling edge; it follows r2_r to zero after reset.
    always_ff @(negedge clk) begin
        r2n_r <= r2_r;
    end

    // Next-state and step decisions for the tap-move sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        tgt_s     = tgt_r;
        tap_cur_s = tap_cur_r;
        ce_s      = 1'b0;
        inc_s     = inc_r;
        abort_s   = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (accept_s) begin
                    tgt_s = req_tgt_s;
                    if (req_tgt_s != tap_cur_r) begin
                        state_s = VTC_OFF_S;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = IDLE_S;
                    end
                end else begin
                    state_s = IDLE_S;
                end
            end
            VTC_OFF_S: begin
                if (cnt_r == CNT_W'(VTC_SETTLE - 1)) begin
                    state_s = STEP_S;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            STEP_S: begin
                cnt_s = {CNT_W{1'b0}};
                if (!rdy_dlyctrl) begin
                    abort_s = 1'b1;
                    state_s = VTC_ON_S;
                end else if (tap_cur_r == tgt_r) begin
                    state_s = VTC_ON_S;
                end else begin
                    // Direction is decided per step so the walk can never overshoot the target.
                    ce_s      = 1'b1;
                    inc_s     = (tgt_r > tap_cur_r);
                    tap_cur_s = (tgt_r > tap_cur_r) ? tap_cur_r + TAP_WIDTH'(1)
                                                    : tap_cur_r - TAP_WIDTH'(1);
                    state_s   = GAP_S;
                end
            end
            GAP_S: begin
                if (cnt_r == CNT_W'(STEP_GAP - 2)) begin
                    state_s = STEP_S;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            VTC_ON_S: begin
                if (cnt_r == CNT_W'(VTC_SETTLE - 1)) begin
                    state_s = IDLE_S;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE_S;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state plus registered delay-line strobes and status, decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE_S;
            cnt_r     <= {CNT_W{1'b0}};
            tgt_r     <= DEFAULT_TAP_C;
            tap_cur_r <= DEFAULT_TAP_C;
            ce_r      <= 1'b0;
            inc_r     <= 1'b0;
            abort_r   <= 1'b0;
            en_vtc_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tgt_r     <= tgt_s;
            tap_cur_r <= tap_cur_s;
            ce_r      <= ce_s;
            inc_r     <= inc_s;
            abort_r   <= abort_s;
            en_vtc_r  <= (state_s == IDLE_S) || (state_s == VTC_ON_S);
            busy_r    <= (state_s != IDLE_S);
        end
    end
endmodule

// File: tb/tb_oddr_tap_ctrl.sv
// Bench for oddr_tap_ctrl: timeline model of the tap walk and DDR phases, checked every clock.
module tb_oddr_tap_ctrl;
    localparam int W    = 4;
    localparam int TW   = 10;
    localparam int MAXT = 511;
    localparam int DEFT = 25;
    localparam int SETL = 8;
    localparam int GAP  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic [W-1:0]  d1, d2, q;
    logic          dly_ce, dly_inc, dly_en_vtc;

    int n_tests = 0;
    int n_fail  = 0;

    oddr_tap_ctrl_if #(.TAP_WIDTH(TW)) tif ();

    oddr_tap_ctrl #(
        .WIDTH(W), .TAP_WIDTH(TW), .MAX_TAP(MAXT), .DEFAULT_TAP(DEFT),
        .VTC_SETTLE(SETL), .STEP_GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .d1(d1), .d2(d2), .q(q), .rdy_dlyctrl(rdy),
        .tap(tif), .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_en_vtc(dly_en_vtc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a move is a timeline measured from its accept edge. First step decision comes
    // SETL+1 edges later, then one every GAP edges; VT compensation returns SETL edges before idle.
    bit          m_valid = 1'b0;
    bit          m_active, m_ended, m_ce, m_inc, m_abort;
    int          m_cur, m_tgt, m_a, m_d, cyc = 0;
    logic [W-1:0] exp_hi, exp_lo;
    int          ce_cnt = 0, abort_cnt = 0;

    initial begin
        int t, rel;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_valid = 1'b1; m_active = 1'b0; m_ended = 1'b0;
                m_ce = 1'b0; m_inc = 1'b0; m_abort = 1'b0; m_cur = DEFT;
                exp_hi = '0; exp_lo = '0;
            end else if (m_valid) begin
                exp_hi = d1; exp_lo = d2; m_ce = 1'b0; m_abort = 1'b0;
                if (!m_active) begin
                    if (tif.tap_valid && rdy) begin
                        t = (int'(tif.tap_target) > MAXT) ? MAXT : int'(tif.tap_target);
                        if (t != m_cur) begin
                            m_active = 1'b1; m_ended = 1'b0; m_a = cyc; m_tgt = t;
                        end
                    end
                end else begin
                    rel = cyc - m_a;
                    if (!m_ended && rel >= SETL + 1 && (rel - SETL - 1) % GAP == 0) begin
                        if (!rdy) begin
                            m_abort = 1'b1; m_ended = 1'b1; m_d = cyc;
                        end else if (m_cur == m_tgt) begin
                            m_ended = 1'b1; m_d = cyc;
                        end else begin
                            m_ce = 1'b1; m_inc = (m_tgt > m_cur);
                            m_cur = m_inc ? m_cur + 1 : m_cur - 1;
                        end
                    end else if (m_ended && cyc == m_d + SETL) begin
                        m_active = 1'b0;
                    end
                end
            end
            #1;
            if (m_valid) begin
                chk("q_hi", 32'(q), 32'(exp_hi));
                chk("tap_current", 32'(tif.tap_current), m_cur);
                chk("busy", 32'(tif.busy), 32'(m_active));
                chk("en_vtc", 32'(dly_en_vtc), 32'(!m_active || m_ended));
                chk("dly_ce", 32'(dly_ce), 32'(m_ce));
                chk("dly_inc", 32'(dly_inc), 32'(m_inc));
                chk("tap_abort", 32'(tif.tap_abort), 32'(m_abort));
                chk("tap_ready", 32'(tif.tap_ready), 32'(!m_active && rdy && !rst));
                if (dly_ce === 1'b1) ce_cnt++;
                if (tif.tap_abort === 1'b1) abort_cnt++;
            end
            @(negedge clk);
            #1;
            if (m_valid) chk("q_lo", 32'(q), 32'(exp_lo));
        end
    end

    task automatic request(input int t);
        bit got = 1'b0;
        @(negedge clk);
        tif.tap_target = TW'(t);
        tif.tap_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (tif.tap_ready === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL req_accept: got 0 expected 1 (target %0d)", t); end
        @(negedge clk);
        tif.tap_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            d1 = W'($urandom); d2 = W'($urandom);
            if (!m_active) begin done = 1'b1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL wait_idle: got busy expected idle within %0d", bound); end
    endtask

    task automatic wait_ce(input int base, input int n);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ce_cnt - base >= n) begin done = 1'b1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL wait_ce: got %0d expected %0d", ce_cnt - base, n); end
    endtask

    initial begin
        int c0, a0;
        logic [W-1:0] v1, v2;
        rst = 1'b1; rdy = 1'b1; d1 = '0; d2 = '0;
        tif.tap_target = '0; tif.tap_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        chk("rst_tap_current", 32'(tif.tap_current), 32'd25);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_en_vtc", 32'(dly_en_vtc), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // toggle pattern: q high phase 1, low phase 0
        d1 = 4'd1; d2 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2; chk("toggle_hi", 32'(q), 32'd1);
            @(negedge clk); #2; chk("toggle_lo", 32'(q), 32'd0);
        end

        // walking pattern appears in presentation order
        for (int k = 0; k < 6; k++) begin
            v1 = W'(3 * k + 1); v2 = W'(3 * k + 2);
            d1 = v1; d2 = v2;
            @(posedge clk); #2; chk("walk_hi", 32'(q), 32'(v1));
            @(negedge clk); #2; chk("walk_lo", 32'(q), 32'(v2));
        end

        // 25 -> 28: three increment steps
        c0 = ce_cnt;
        request(28); wait_idle(300);
        chk("mv28_tap", 32'(tif.tap_current), 32'd28);
        chk("mv28_model", m_cur, 32'd28);
        chk("mv28_pulses", ce_cnt - c0, 32'd3);

        // same target is accepted as a no-op
        c0 = ce_cnt;
        request(28);
        repeat (20) @(negedge clk);
        chk("noop_pulses", ce_cnt - c0, 32'd0);
        chk("noop_busy", 32'(tif.busy), 32'd0);

        // clamp above MAX_TAP, then walk all the way down
        request(509); wait_idle(3000);
        chk("mv509_tap", 32'(tif.tap_current), 32'd509);
        c0 = ce_cnt;
        request(600); wait_idle(300);
        chk("clamp_tap", 32'(tif.tap_current), 32'd511);
        chk("clamp_pulses", ce_cnt - c0, 32'd2);
        c0 = ce_cnt;
        request(0); wait_idle(3000);
        chk("mv0_tap", 32'(tif.tap_current), 32'd0);
        chk("mv0_pulses", ce_cnt - c0, 32'd511);

        // rdy_dlyctrl lost after two of five steps
        c0 = ce_cnt; a0 = abort_cnt;
        request(5); wait_ce(c0, 2);
        @(negedge clk); rdy = 1'b0;
        wait_idle(300);
        chk("abort_pulses", abort_cnt - a0, 32'd1);
        chk("abort_tap", 32'(tif.tap_current), 32'd2);
        chk("abort_en_vtc", 32'(dly_en_vtc), 32'd1);
        @(negedge clk); rdy = 1'b1;

        // reset in the middle of a move
        c0 = ce_cnt;
        request(20); wait_ce(c0, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        chk("rstmv_tap", 32'(tif.tap_current), 32'd25);
        chk("rstmv_busy", 32'(tif.busy), 32'd0);
        chk("rstmv_en_vtc", 32'(dly_en_vtc), 32'd1);
        chk("rstmv_ce", 32'(dly_ce), 32'd0);
        chk("rstmv_q", 32'(q), 32'd0);
        @(negedge clk); rst = 1'b0;
        request(27); wait_idle(300);
        chk("post_rst_tap", 32'(tif.tap_current), 32'd27);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
